// File: rtl/pkt_rr_arb8.sv
// Packet-level round-robin arbiter and mux for 8 upstream packet sources.
// A grant is held from the first beat through the eop beat, so packets
// never interleave. After each packet, priority rotates to the port that
// follows the last granted one. The output stage is a single register slice
// whose contents stay stable while the downstream side stalls.
module pkt_rr_arb8 #(
   parameter int DATA_W    = 256,
   parameter int REQ_NUM   = 8,
   parameter int REQ_NUM_W = 3
) (
   input  logic                      clks,
   input  logic                      reset,
   input  logic [REQ_NUM-1:0]        req_mask,
   input  logic [REQ_NUM-1:0]        s_vld,
   input  logic [REQ_NUM*DATA_W-1:0] s_data,
   input  logic [REQ_NUM-1:0]        s_eop,
   output logic [REQ_NUM-1:0]        s_rdy,
   output logic                      m_vld,
   output logic [DATA_W-1:0]         m_data,
   output logic                      m_eop,
   output logic [REQ_NUM_W-1:0]      m_src,
   input  logic                      m_rdy,
   output logic                      gnt_vld,
   output logic [REQ_NUM_W-1:0]      gnt_id
);

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   state_t               state;
   logic [REQ_NUM_W-1:0] ptr;       // last granted port
   logic [REQ_NUM_W-1:0] winner;
   logic [REQ_NUM-1:0]   req;
   logic                 out_free;
   logic                 beat_acc;
   logic                 cur_vld;
   logic                 cur_eop;
   logic [DATA_W-1:0]    cur_data;

   // Ports allowed to compete; the mask only matters while arbitrating.
   assign req      = s_vld & req_mask;

   // The output register can take a new beat when empty or draining this cycle.
   assign out_free = !m_vld | m_rdy;

   // Beat currently offered by the granted port.
   assign cur_vld  = s_vld[gnt_id];
   assign cur_eop  = s_eop[gnt_id];
   assign cur_data = s_data[gnt_id*DATA_W +: DATA_W];

   assign beat_acc = (state == ST_XFER) && cur_vld && out_free;

   // Round-robin search starting at ptr+1; walking the offsets from farthest
   // to nearest lets the nearest requesting port overwrite the result.
   always_comb begin
      logic [REQ_NUM_W-1:0] idx;
      // NOTE: every variable assigned in a combinational block gets a default
      // first, so no path leaves it holding a value and no latch is inferred.
      winner = ptr;
      idx    = '0;
      for (int i = REQ_NUM; i >= 1; i--) begin
         // offset REQ_NUM wraps to 0, so ptr itself is the last candidate
         idx = ptr + REQ_NUM_W'(i);
         if (req[idx]) begin
            winner = idx;
         end
      end
   end

   // Ready goes only to the granted port, and drops in the same cycle as a stall.
   always_comb begin
      s_rdy = '0;
      if (state == ST_XFER) begin
         s_rdy[gnt_id] = out_free;
      end
   end

   // Arbitration FSM, grant status, rotation pointer and output register slice.
   always_ff @(posedge clks or posedge reset) begin
      // NOTE: state is updated only with non-blocking assignments so every
      // register samples the values from before the clock edge.
      if (reset) begin
         state   <= ST_ARB;
         ptr     <= REQ_NUM_W'(REQ_NUM - 1);
         gnt_id  <= '0;
         gnt_vld <= 1'b0;
         m_vld   <= 1'b0;
         m_eop   <= 1'b0;
         m_src   <= '0;
         m_data  <= '0;
      end else begin
         case (state)
            ST_ARB: begin
               if (req != '0) begin
                  gnt_id  <= winner;
                  gnt_vld <= 1'b1;
                  state   <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (beat_acc && cur_eop) begin
                  ptr     <= gnt_id;
                  gnt_vld <= 1'b0;
                  state   <= ST_ARB;
               end
            end
            default: begin
               state <= ST_ARB;
            end
         endcase

         // The output slice loads on an accepted beat and empties once drained.
         if (beat_acc) begin
            m_data <= cur_data;
            m_eop  <= cur_eop;
            m_src  <= gnt_id;
            m_vld  <= 1'b1;
         end else if (m_rdy) begin
            m_vld  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pkt_rr_arb8.sv
// Self-checking bench for pkt_rr_arb8. Packet sources are modelled per port,
// expected output beats are queued in arbitration order as each scenario is
// set up, and a monitor pops and compares them as beats leave the arbiter.
module tb_pkt_rr_arb8;

   localparam int DATA_W = 256;
   localparam int N      = 8;

   typedef struct {
      logic [2:0]        src;
      logic [DATA_W-1:0] data;
      logic              eop;
   } beat_t;

   logic              clks = 1'b0;
   logic              reset = 1'b1;
   logic [N-1:0]      req_mask = '1;
   logic [N-1:0]      s_vld = '0;
   logic [N*DATA_W-1:0] s_data = '0;
   logic [N-1:0]      s_eop = '0;
   logic [N-1:0]      s_rdy;
   logic              m_vld;
   logic [DATA_W-1:0] m_data;
   logic              m_eop;
   logic [2:0]        m_src;
   logic              m_rdy = 1'b1;
   logic              gnt_vld;
   logic [2:0]        gnt_id;

   int    n_cmp = 0;
   int    n_err = 0;
   beat_t exp_q[$];

   // source model state
   int src_len[N];
   int src_beat[N];
   int src_pkts[N];
   int src_seq[N];
   bit rdy_toggle = 1'b0;

   // monitor state
   int    cyc = 0;
   int    beat_cyc[$];
   int    n_stall = 0;
   bit    stalled = 1'b0;
   beat_t held;

   pkt_rr_arb8 #(.DATA_W(DATA_W), .REQ_NUM(N), .REQ_NUM_W(3)) dut (
      .clks     (clks),
      .reset    (reset),
      .req_mask (req_mask),
      .s_vld    (s_vld),
      .s_data   (s_data),
      .s_eop    (s_eop),
      .s_rdy    (s_rdy),
      .m_vld    (m_vld),
      .m_data   (m_data),
      .m_eop    (m_eop),
      .m_src    (m_src),
      .m_rdy    (m_rdy),
      .gnt_vld  (gnt_vld),
      .gnt_id   (gnt_id)
   );

   always #5 clks = ~clks;

   function automatic logic [DATA_W-1:0] mk_data(int p, int seq, int b);
      logic [31:0] w;
      w = {8'(p), 8'(seq), 8'(b), 8'hA5};
      return {8{w}};
   endfunction

   task automatic push_pkt(int p, int seq, int len);
      beat_t e;
      for (int b = 0; b < len; b++) begin
         e.src  = 3'(p);
         e.data = mk_data(p, seq, b);
         e.eop  = (b == len - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clks);
      #3;
   endtask

   // Upstream sources and downstream ready: sample transfers at the falling
   // edge, advance the packet state just after the rising edge.
   initial begin
      logic [N-1:0] take;
      forever begin
         @(negedge clks);
         take = s_vld & s_rdy;
         @(posedge clks);
         #1;
         for (int i = 0; i < N; i++) begin
            if (take[i]) begin
               src_beat[i]++;
               if (src_beat[i] == src_len[i]) begin
                  src_beat[i] = 0;
                  src_pkts[i]--;
                  src_seq[i]++;
               end
            end
            s_vld[i]                     = (src_pkts[i] > 0);
            s_eop[i]                     = (src_beat[i] == src_len[i] - 1);
            s_data[i*DATA_W +: DATA_W]   = mk_data(i, src_seq[i], src_beat[i]);
         end
         m_rdy = rdy_toggle ? ~m_rdy : 1'b1;
      end
   end

   // Output monitor: scoreboard compare, stall stability and one-hot ready.
   initial begin
      beat_t e;
      forever begin
         @(negedge clks);
         cyc++;
         if (reset) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               n_cmp++;
               if (m_vld !== 1'b1 || m_data !== held.data || m_src !== held.src || m_eop !== held.eop) begin
                  n_err++;
                  $display("FAIL stall_hold: got vld=%b src=%0d eop=%b data=%h, need vld=1 src=%0d eop=%b data=%h",
                           m_vld, m_src, m_eop, m_data, held.src, held.eop, held.data);
               end
            end
            stalled = 1'b0;
            if (m_vld && !m_rdy) begin
               stalled   = 1'b1;
               held.data = m_data;
               held.src  = m_src;
               held.eop  = m_eop;
               n_stall++;
               n_cmp++;
               if (s_rdy !== 8'h00) begin
                  n_err++;
                  $display("FAIL stall_s_rdy: got s_rdy=%b, need 00000000", s_rdy);
               end
            end
            if (m_vld && m_rdy) begin
               beat_cyc.push_back(cyc);
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_beat: got src=%0d eop=%b, need no beat", m_src, m_eop);
               end else begin
                  e = exp_q.pop_front();
                  if (m_src !== e.src || m_data !== e.data || m_eop !== e.eop) begin
                     n_err++;
                     $display("FAIL out_beat: got src=%0d eop=%b data=%h, need src=%0d eop=%b data=%h",
                              m_src, m_eop, m_data, e.src, e.eop, e.data);
                  end
               end
            end
            if ($countones(s_rdy) > 1) begin
               n_cmp++;
               n_err++;
               $display("FAIL s_rdy_onehot: got s_rdy=%b, need at most one bit", s_rdy);
            end
         end
      end
   end

   task automatic wait_drain(int max_cyc, string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         @(negedge clks);
         n++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_timeout: got %0d beats still pending, need 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clks);
      @(negedge clks);
      n_cmp++;
      if ({m_vld, m_eop, gnt_vld, s_rdy, gnt_id, m_src} !== 16'h0000) begin
         n_err++;
         $display("FAIL reset_ctrl: got vld=%b eop=%b gnt_vld=%b s_rdy=%b gnt_id=%0d src=%0d, need all 0",
                  m_vld, m_eop, gnt_vld, s_rdy, gnt_id, m_src);
      end
      n_cmp++;
      if (m_data !== '0) begin
         n_err++;
         $display("FAIL reset_data: got %h, need 0", m_data);
      end
      tick();
      reset = 1'b0;
      @(negedge clks);
      n_cmp++;
      if ({m_vld, gnt_vld, s_rdy} !== 10'h000) begin
         n_err++;
         $display("FAIL idle_after_reset: got vld=%b gnt_vld=%b s_rdy=%b, need all 0", m_vld, gnt_vld, s_rdy);
      end
   endtask

   // Test 1: eight single-beat sources, two packets each, full downstream ready.
   task automatic test_all_ports();
      tick();
      beat_cyc.delete();
      for (int r = 0; r < 2; r++) begin
         for (int p = 0; p < N; p++) begin
            push_pkt(p, src_seq[p] + r, 1);
         end
      end
      for (int p = 0; p < N; p++) begin
         src_len[p]  = 1;
         src_pkts[p] = 2;
      end
      wait_drain(200, "all_ports");
      n_cmp++;
      if (beat_cyc.size() != 16) begin
         n_err++;
         $display("FAIL all_ports_count: got %0d beats, need 16", beat_cyc.size());
      end else begin
         for (int k = 1; k < 16; k++) begin
            n_cmp++;
            if (beat_cyc[k] - beat_cyc[k-1] != 2) begin
               n_err++;
               $display("FAIL all_ports_spacing: got %0d cycles between beats %0d and %0d, need 2",
                        beat_cyc[k] - beat_cyc[k-1], k - 1, k);
            end
         end
      end
   endtask

   // Test 2: 4-beat packet on port 3 with port 5 waiting, downstream ready toggling.
   task automatic test_stall();
      int stalls_before;
      tick();
      stalls_before = n_stall;
      push_pkt(3, src_seq[3], 4);
      push_pkt(5, src_seq[5], 1);
      rdy_toggle  = 1'b1;
      src_len[3]  = 4;
      src_pkts[3] = 1;
      src_len[5]  = 1;
      src_pkts[5] = 1;
      wait_drain(200, "stall");
      rdy_toggle = 1'b0;
      n_cmp++;
      if (n_stall == stalls_before) begin
         n_err++;
         $display("FAIL stall_seen: got 0 stalled cycles, need at least 1");
      end
      repeat (3) tick();
   endtask

   // Test 3: port 6 alone, re-granted while it is also the last grant.
   task automatic test_single_requester();
      int n;
      tick();
      push_pkt(6, src_seq[6], 1);
      src_len[6]  = 1;
      src_pkts[6] = 1;
      wait_drain(50, "single_first");
      repeat (4) tick();
      push_pkt(6, src_seq[6], 1);
      src_pkts[6] = 1;
      n = 0;
      while (!s_vld[6] && n < 20) begin
         @(negedge clks);
         n++;
      end
      n = 0;
      while (!m_vld && n < 10) begin
         @(negedge clks);
         n++;
         if (n == 1) begin
            n_cmp++;
            if (gnt_vld !== 1'b1 || gnt_id !== 3'd6 || s_rdy !== 8'h40) begin
               n_err++;
               $display("FAIL regrant: got gnt_vld=%b gnt_id=%0d s_rdy=%b, need 1 6 01000000",
                        gnt_vld, gnt_id, s_rdy);
            end
         end
      end
      n_cmp++;
      if (n != 2) begin
         n_err++;
         $display("FAIL regrant_latency: got %0d cycles, need 2", n);
      end
      wait_drain(50, "single_second");
   endtask

   // Test 4: upper-half mask with every port requesting.
   task automatic test_mask();
      int  n;
      bit  low_rdy;
      tick();
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      req_mask = 8'hF0;
      push_pkt(4, src_seq[4], 1);
      push_pkt(5, src_seq[5], 1);
      push_pkt(6, src_seq[6], 1);
      push_pkt(7, src_seq[7], 1);
      push_pkt(4, src_seq[4] + 1, 1);
      for (int p = 0; p < N; p++) begin
         src_len[p]  = 1;
         src_pkts[p] = (p == 4) ? 2 : 1;
      end
      low_rdy = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clks);
         n++;
         if (s_rdy[3:0] != 4'b0000) low_rdy = 1'b1;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL mask_timeout: got %0d beats pending, need 0", exp_q.size());
         exp_q.delete();
      end
      n_cmp++;
      if (low_rdy) begin
         n_err++;
         $display("FAIL mask_low_rdy: got s_rdy[3:0] set at least once, need always 0000");
      end
      tick();
      for (int p = 0; p < 4; p++) src_pkts[p] = 0;
      repeat (2) tick();
      req_mask = 8'hFF;
   endtask

   // Test 5: mask dropped for the granted port mid-packet.
   task automatic test_mask_midpacket();
      int n;
      bit regrant;
      tick();
      push_pkt(2, src_seq[2], 3);
      src_len[2]  = 3;
      src_pkts[2] = 2;
      n = 0;
      while (!(s_vld[2] && s_rdy[2]) && n < 20) begin
         @(negedge clks);
         n++;
      end
      tick();
      req_mask = 8'hFB;
      push_pkt(1, src_seq[1], 1);
      src_len[1]  = 1;
      src_pkts[1] = 1;
      wait_drain(50, "mask_mid");
      regrant = 1'b0;
      repeat (8) begin
         @(negedge clks);
         if (gnt_vld || s_rdy[2]) regrant = 1'b1;
      end
      n_cmp++;
      if (regrant) begin
         n_err++;
         $display("FAIL masked_regrant: got port 2 granted again, need no grant");
      end
      tick();
      src_pkts[2] = 0;
      repeat (2) tick();
      req_mask = 8'hFF;
   endtask

   // Test 6: reset during a 5-beat packet, then all ports request.
   task automatic test_reset_midpacket();
      int n;
      tick();
      src_len[4]  = 5;
      src_pkts[4] = 1;
      n = 0;
      while (!(s_vld[4] && s_rdy[4]) && n < 20) begin
         @(negedge clks);
         n++;
      end
      tick();
      reset = 1'b1;
      for (int p = 0; p < N; p++) begin
         src_pkts[p] = 0;
         src_beat[p] = 0;
      end
      @(negedge clks);
      n_cmp++;
      if ({m_vld, gnt_vld, s_rdy} !== 10'h000) begin
         n_err++;
         $display("FAIL reset_mid: got vld=%b gnt_vld=%b s_rdy=%b, need all 0", m_vld, gnt_vld, s_rdy);
      end
      tick();
      reset = 1'b0;
      for (int p = 0; p < N; p++) begin
         push_pkt(p, src_seq[p], 1);
         src_len[p]  = 1;
         src_pkts[p] = 1;
      end
      n = 0;
      while (!gnt_vld && n < 20) begin
         @(negedge clks);
         n++;
      end
      n_cmp++;
      if (gnt_vld !== 1'b1 || gnt_id !== 3'd0) begin
         n_err++;
         $display("FAIL first_after_reset: got gnt_vld=%b gnt_id=%0d, need 1 0", gnt_vld, gnt_id);
      end
      wait_drain(100, "after_reset");
   endtask

   initial begin
      test_reset();
      test_all_ports();
      test_stall();
      test_single_requester();
      test_mask();
      test_mask_midpacket();
      test_reset_midpacket();
      repeat (5) @(negedge clks);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pkt_rr_arb8.md
Name: pkt_rr_arb8

Overview:
- Packet-level round-robin arbiter and mux: shares one downstream stream interface between 8 upstream packet sources.
- Grant is held for a whole packet, from first beat through the eop beat, so packets never interleave.
- After each packet, priority rotates to the port after the last granted one.
- Sits in front of shared datapath resources (DMA/queue write ports) in the user logic.

Parameters:
- DATA_W, 256, width of one data beat per port.
- REQ_NUM, 8, number of requesters; fixed at 8, the only supported value.
- REQ_NUM_W, 3, width of the port index.

Ports:
- clks  in  1  clock.
- reset  in  1  reset.
- req_mask  in  8  per-port enable; 1 = port may win arbitration.
- s_vld  in  8  per-port beat valid.
- s_data  in  8*DATA_W  per-port beat data; port i occupies bits [i*DATA_W +: DATA_W].
- s_eop  in  8  per-port end-of-packet flag, qualified by s_vld.
- s_rdy  out  8  per-port ready; at most one bit set.
- m_vld  out  1  output beat valid.
- m_data  out  DATA_W  output beat data.
- m_eop  out  1  output end-of-packet.
- m_src  out  3  source port index of the output beat.
- m_rdy  in  1  downstream ready.
- gnt_vld  out  1  arbiter in XFER state (status).
- gnt_id  out  3  currently granted port (status).

Behaviour:
- Reset is asynchronous and active-high on reset; clock is clks.
- Reset values:
  - state = ARB, last-grant pointer ptr = 7 (so port 0 has highest priority first).
  - gnt_id = 0, gnt_vld = 0, s_rdy = 0.
  - m_vld = 0, m_eop = 0, m_src = 0, m_data = 0.
- Handshakes:
  - Upstream beat transfers when s_vld[i] & s_rdy[i].
  - Downstream beat transfers when m_vld & m_rdy.
  - m_vld/m_data/m_eop/m_src hold stable while m_vld=1 and m_rdy=0.
- Eligible set: req = s_vld & req_mask.
- State ARB:
  - If req != 0, winner = first set bit of req searching ptr+1, ptr+2, ... with wrap modulo 8 (3-bit arithmetic).
  - On a winner: gnt_id <= winner, gnt_vld <= 1, state <= XFER.
  - If req == 0: stay in ARB.
  - s_rdy = 0 throughout ARB.
- State XFER:
  - out_free = !m_vld | m_rdy.
  - s_rdy[gnt_id] = out_free; all other s_rdy bits = 0.
  - On an accepted beat: m_data <= s_data[gnt_id], m_eop <= s_eop[gnt_id], m_src <= gnt_id, m_vld <= 1.
  - Accepted beat with eop = 1: ptr <= gnt_id, gnt_vld <= 0, state <= ARB.
  - No beat accepted and m_rdy = 1: m_vld <= 0.
- Latency:
  - Eligible request seen in ARB at cycle N -> s_rdy asserted at N+1 -> first beat on m_* at N+2.
  - One arbitration bubble per packet; full throughput within a packet.
- Single-beat packet (eop on first beat): XFER lasts exactly 1 accepted beat, then back to ARB.
- A port gaps s_vld mid-packet: grant is held and no other port may interleave.
- req_mask deasserted for the granted port mid-packet: packet still completes. Mask only affects arbitration in ARB.
- Only one requester eligible: it wins regardless of ptr, including when it was the last grant (wrap of the search back to ptr itself).
- Output stall (m_rdy = 0 while m_vld = 1): s_rdy drops to 0 in the same cycle (combinational from m_rdy); no beat is lost or duplicated.
- Reset mid-packet: everything returns to reset values immediately. A partially sent packet is truncated, and upstream must also be reset.
- s_eop and s_data of ports without a grant are ignored.

Test Plan:
1. All 8 ports, each sending one 1-beat packet continuously, m_rdy = 1 -> grant order 0,1,2,...,7,0; one m_vld beat every 2 cycles; m_src matches.
2. Port 3 sends a 4-beat packet while port 5 requests; m_rdy toggles 1,0,1,0 -> 4 beats from port 3 contiguous with m_src = 3, data unchanged during stalls; then port 5 is granted.
3. Only port 6 requests, with ptr = 6 after its previous packet -> port 6 is re-granted; first beat on m_* 2 cycles after the request.
4. req_mask = 8'hF0, all s_vld = 1 -> only ports 4..7 are granted, in order 4,5,6,7,4; ports 0..3 have s_rdy = 0 throughout.
5. Port 2 granted, req_mask[2] cleared after beat 1 of a 3-beat packet -> beats 2 and 3 complete, then port 2 is not re-arbitrated.
6. Assert reset during beat 2 of a 5-beat packet -> the next cycle shows m_vld = 0, s_rdy = 0, gnt_vld = 0; after release with all ports requesting, port 0 wins first.
